// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory arbiter.
//   state_t    : arbiter FSM states
//   req_id_t   : requester index (0 = core LSU, 1 = debug/DMA)
//   WORD_BYTES : bytes per data_mem word (addresses must be multiples of this)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam int WORD_BYTES = 8;
  localparam int NUM_REQ    = 2;

  // One-hot two-bit grant to requester index.
  function automatic req_id_t grant_to_id(input logic [1:0] grant);
    return req_id_t'(grant[1]);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst  : clock, asynchronous active-high reset (priority back to requester 0)
//   i_enable  : grants are only issued while high
//   i_req     : request vector
//   o_grant   : one-hot grant (0 when disabled or nothing requested)
// Every non-zero grant is taken as accepted, and the other requester then
// becomes preferred.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  req_id_t r_prio;  // requester that wins a tie

  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (|o_grant) begin
      // Granting 0 hands priority to 1 and vice versa.
      r_prio <= req_id_t'(o_grant[0]);
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data_mem.
// A request is accepted in IDLE, the memory is enabled for one cycle in
// ACCESS, and the response pulses in RESP: accepted on edge N, the requester
// samples rsp_valid on edge N+2; one transaction every three cycles at most.
// Misaligned addresses (addr[2:0] != 0) never reach memory and return rsp_err.
// Optional feature macro: DMEM_ROM_PROTECT_EN -- writes below ROM_SIZE words
// are refused with rsp_err instead of being forwarded.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   req_valid/req_ready [1:0]      : per-requester handshake
//   req_we, req_addr, req_wdata    : per-requester command
//   rsp_valid [1:0], rsp_err, rsp_rdata : response to the owning requester
//   mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable, mem_rd_data : data_mem
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ROM_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wr_data,
  output logic                   mem_wr_enable,
  output logic                   mem_rd_enable,
  input  logic [DATA_W-1:0]      mem_rd_data
);

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          w_grant;
  logic                w_accept;
  req_id_t             w_sel;
  logic                w_misaligned;
  logic                w_rom_err;
  req_id_t             r_owner;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_enable (r_state == IDLE),
    .i_req    (req_valid),
    .o_grant  (w_grant)
  );

  // The grant is only non-zero for a valid requester, so a grant is a transfer.
  assign w_accept     = |w_grant;
  assign w_sel        = grant_to_id(w_grant);
  assign w_misaligned = (req_addr[w_sel][2:0] != 3'b000);

`ifdef DMEM_ROM_PROTECT_EN
  localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_SIZE * WORD_BYTES);
  assign w_rom_err = req_we[w_sel] && (req_addr[w_sel] < ROM_LIMIT);
`else
  assign w_rom_err = 1'b0;
`endif

  // req_ready is combinational from the grant, so it is also masked by rst
  // to drop immediately when reset is applied.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_ready[gi] = ~rst & w_grant[gi];
    assign rsp_valid[gi] = (r_state == RESP) && (r_owner == req_id_t'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_owner <= w_sel;
      r_we    <= req_we[w_sel];
      r_err   <= w_misaligned | w_rom_err;
      r_addr  <= req_addr[w_sel];
      r_wdata <= req_wdata[w_sel];
    end
  end

  always_comb begin
    w_state_next  = r_state;
    mem_addr      = '0;
    mem_wr_data   = '0;
    mem_wr_enable = 1'b0;
    mem_rd_enable = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = ACCESS;
      end
      ACCESS: begin
        mem_addr    = r_addr;
        mem_wr_data = r_wdata;
        if (!r_err) begin
          mem_wr_enable = r_we;
          mem_rd_enable = ~r_we;
        end
        w_state_next = RESP;
      end
      RESP: begin
        // data_mem presents read data the cycle after the enable.
        rsp_err = r_err;
        if (!r_we && !r_err) rsp_rdata = mem_rd_data;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][31:0]  req_addr;
  logic [1:0][63:0]  req_wdata;
  logic [1:0]        rsp_valid;
  logic              rsp_err;
  logic [63:0]       rsp_rdata;
  logic [31:0]       mem_addr;
  logic [63:0]       mem_wr_data;
  logic              mem_wr_enable;
  logic              mem_rd_enable;
  logic [63:0]       mem_rd_data = 64'h0;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_rdata     (rsp_rdata),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_enable (mem_wr_enable),
    .mem_rd_enable (mem_rd_enable),
    .mem_rd_data   (mem_rd_data)
  );

  // data_mem model: 256 words, words 0..15 are ROM holding word index + 1,
  // writes to ROM are ignored, read data registered one cycle after enable.
  logic [63:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_wr_enable) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr[10:3] >= 8'd16) ram[mem_addr[10:3]] <= mem_wr_data;
    end
    if (mem_rd_enable) begin
      rd_cnt <= rd_cnt + 1;
      if (mem_addr[10:3] < 8'd16) mem_rd_data <= {56'h0, mem_addr[10:3]} + 64'd1;
      else                        mem_rd_data <= ram[mem_addr[10:3]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input logic [1:0] mask, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((req_ready & mask) != 2'b00) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic do_txn(input string tag, input int id, input logic we,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input logic exp_err, input logic [63:0] exp_rdata,
                        input int exp_wr, input int exp_rd);
    logic       ok;
    int         wr0;
    int         rd0;
    logic [1:0] exp_vec;
    exp_vec       = 2'b01 << id;
    wr0           = wr_cnt;
    rd0           = rd_cnt;
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    req_addr[id]  = addr;
    req_wdata[id] = wdata;
    wait_ready(2'b11, ok);
    chk({tag, "_ready"}, {62'h0, req_ready}, {62'h0, exp_vec});
    if (!ok) begin
      req_valid = 2'b00;
      return;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    chk({tag, "_access_rsp"}, {62'h0, rsp_valid}, 64'h0);
    @(posedge clk); #1;
    chk({tag, "_rsp_valid"}, {62'h0, rsp_valid}, {62'h0, exp_vec});
    chk({tag, "_rsp_err"}, {63'h0, rsp_err}, {63'h0, exp_err});
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    @(posedge clk); #1;
    chk({tag, "_idle_rsp"}, {61'h0, rsp_err, rsp_valid}, 64'h0);
    chk({tag, "_mem_wr_cnt"}, 64'(wr_cnt - wr0), 64'(exp_wr));
    chk({tag, "_mem_rd_cnt"}, 64'(rd_cnt - rd0), 64'(exp_rd));
    $display("txn %s: req=%0d we=%0b addr=%h err=%0b rdata=%h", tag, id, we, addr, rsp_err, rsp_rdata);
  endtask

  initial begin
    logic       ok;
    logic       prot_err;
    int         prot_wr;
    logic [1:0] exp_g;
`ifdef DMEM_ROM_PROTECT_EN
    prot_err = 1'b1;
    prot_wr  = 0;
`else
    prot_err = 1'b0;
    prot_wr  = 1;
`endif
    rst       = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    #2;
    chk("reset_ready", {62'h0, req_ready}, 64'h0);
    chk("reset_rsp", {61'h0, rsp_err, rsp_valid}, 64'h0);
    chk("reset_rdata", rsp_rdata, 64'h0);
    chk("reset_mem_en", {62'h0, mem_wr_enable, mem_rd_enable}, 64'h0);
    chk("reset_mem_addr", {32'h0, mem_addr}, 64'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", {mem_addr, 28'h0, mem_wr_enable, mem_rd_enable, rsp_valid}, 64'h0);

    do_txn("lsu_wr_80", 0, 1'b1, 32'h80, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 1, 0);
    do_txn("lsu_rd_80", 0, 1'b0, 32'h80, 64'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 0, 1);
    do_txn("dma_rd_80", 1, 1'b0, 32'h80, 64'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 0, 1);
    do_txn("misalign_84", 0, 1'b0, 32'h84, 64'h0, 1'b1, 64'h0, 0, 0);
    do_txn("rom_wr_0", 0, 1'b1, 32'h0, 64'hFFFF_FFFF, prot_err, 64'h0, prot_wr, 0);
    do_txn("rom_rd_0", 0, 1'b0, 32'h0, 64'h0, 1'b0, 64'h1, 0, 1);

    // Reset while a requester-0 write sits in ACCESS.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h100;
    req_wdata[0] = 64'hDEAD_BEEF;
    wait_ready(2'b01, ok);
    chk("rst_txn_ready", {63'h0, ok}, 64'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("rst_txn_access_wr", {63'h0, mem_wr_enable}, 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem", {mem_addr, 30'h0, mem_wr_enable, mem_rd_enable}, 64'h0);
    chk("rst_mid_wdata", mem_wr_data, 64'h0);
    chk("rst_mid_rsp", {61'h0, rsp_err, rsp_valid}, 64'h0);
    chk("rst_mid_rdata", rsp_rdata, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_no_rsp", {62'h0, rsp_valid}, 64'h0);
      @(posedge clk); #1;
    end
    $display("txn rst_during_access: response suppressed");

    // Both requesters continuously valid: grants alternate starting with 0.
    req_we      = 2'b00;
    req_addr[0] = 32'h0;
    req_addr[1] = 32'h8;
    req_valid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready(2'b11, ok);
      chk("alt_grant", {62'h0, req_ready}, {62'h0, exp_g});
      if (!ok) break;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("alt_rsp_valid", {62'h0, rsp_valid}, {62'h0, exp_g});
      chk("alt_rdata", rsp_rdata, (k % 2 == 0) ? 64'h1 : 64'h2);
      $display("txn alt%0d: grant=%b rdata=%h", k, req_ready, rsp_rdata);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
